rom_load_ctrl: RTL
==================

# rom_load_ctrl

Sequences the HPS ROM download into the Asteroids core and owns the core's reset. It sits between the `hps_io` ioctl port and `ASTEROIDS_TOP`. It splits the linear download stream into program-ROM and vector-ROM write strobes, counts and validates the byte total, and holds the core in reset until a valid image is loaded plus a settle interval. It also applies a stretched reset on user/OSD reset requests.

## Interface
Parameters:
- `PROG_SIZE`, 6144: bytes of program ROM, first in the stream
- `VROM_SIZE`, 2048: bytes of vector ROM, immediately after the program ROM
- `HOLD_CYCLES`, 1024: `clk_25` cycles the core stays in reset after a load or a reset request; minimum 1

Ports:
- `clk_25` in 1: system clock (hps_io `clk_sys`)
- `RESET_L` in 1: **asynchronous, active-low reset**
- `ioctl_download` in 1: HPS download active
- `ioctl_wr` in 1: single-cycle byte write strobe
- `ioctl_addr` in 25: byte address within the download
- `ioctl_dout` in 8: byte data
- `user_rst` in 1: level reset request (OSD reset or user button)
- `dn_addr` out 16: region-relative byte address
- `dn_data` out 8: byte data
- `dn_wr_prog` out 1: program-ROM write strobe
- `dn_wr_vrom` out 1: vector-ROM write strobe
- `core_reset_l` out 1: active-low reset to `ASTEROIDS_TOP`
- `load_ok` out 1: a valid image is resident
- `load_err` out 1: the last download was malformed

## Operation
- States: `EMPTY`, `LOAD`, `CHECK`, `HOLD`, `RUN`, `ERROR`.
- After `RESET_L` low: state `EMPTY`, all strobes 0, `dn_addr`/`dn_data` 0, `core_reset_l` 0, `load_ok` 0, `load_err` 0, byte counter 0, hold counter 0.
- `EMPTY`, `HOLD`, `RUN` or `ERROR` with `ioctl_download`=1 → `LOAD`:
  - clear the byte counter, `load_ok` and `load_err`;
  - drive `core_reset_l` 0.
- `LOAD`, for each `ioctl_wr`:
  - address `a` < `PROG_SIZE`: assert `dn_wr_prog`, `dn_addr`=`a`.
  - `PROG_SIZE` ≤ `a` < `PROG_SIZE+VROM_SIZE`: assert `dn_wr_vrom`, `dn_addr`=`a-PROG_SIZE`.
  - `a` ≥ `PROG_SIZE+VROM_SIZE`: no strobe; set the sticky overflow flag.
  - Every write increments the 16-bit byte counter, which saturates at 0xFFFF.
- `LOAD` with `ioctl_download` falling → `CHECK`.
  - A write in the same cycle as the fall is still accepted and counted.
- `CHECK`, one cycle:
  - counter == `PROG_SIZE+VROM_SIZE` and no overflow → `HOLD`, set `load_ok`=1, load the hold counter with `HOLD_CYCLES`.
  - otherwise → `ERROR`, set `load_err`=1.
- `HOLD`:
  - decrement the hold counter each cycle; at 0 → `RUN`.
  - `user_rst`=1 reloads the counter, so reset lasts `HOLD_CYCLES` after `user_rst` releases.
- `RUN`:
  - `core_reset_l`=1.
  - `user_rst`=1 → `HOLD` with the counter reloaded.
- `ERROR`: `core_reset_l`=0; leave only through a new download or `RESET_L`.
- `EMPTY`: `core_reset_l`=0; `user_rst` is ignored.
- Priority when events coincide: `ioctl_download` rising > `user_rst` > hold expiry.
- `ioctl_wr` with `ioctl_download`=0 is ignored in every state.
- `RESET_L` asserted mid-`LOAD` returns to `EMPTY`. The partial image is discarded logically (`load_ok`=0).

## Timing
- Write path is one registered stage. An `ioctl_wr` at cycle N gives a strobe, `dn_addr` and `dn_data` valid at N+1, strobe exactly one cycle wide.
- Back-to-back `ioctl_wr` on consecutive cycles is supported at full rate.
- `core_reset_l`, `load_ok` and `load_err` are registered.
- `ioctl_download` falls at cycle F: `CHECK` at F+1; `HOLD` entered at F+2 with `load_ok`=1; `core_reset_l` rises at F+2+`HOLD_CYCLES`.
- `user_rst` in `RUN` at cycle U: `core_reset_l`=0 at U+1.
- `dn_addr` and `dn_data` hold their last values between strobes.

## Structure
- Shared package `asteroids_pkg` holds:
  - the state enum `rld_state_t`;
  - the region-size constants `ROM_PROG_BYTES`=6144 and `ROM_VROM_BYTES`=2048, used as parameter defaults and by the bench.
- One sub-module, `rld_region_decode`: combinational address → {`prog_hit`, `vrom_hit`, `over`, `rel_addr`}.
- The FSM, counters and output registers live in `rom_load_ctrl`.

## Test plan
- **Reset then nominal load:** `RESET_L` pulse, then 8192 sequential writes with data = addr[7:0].
  - Exactly 6144 `dn_wr_prog` (`dn_addr` 0..6143) and 2048 `dn_wr_vrom` (`dn_addr` 0..2047), each 1 cycle after its `ioctl_wr`.
  - `load_ok`=1 at F+2; `core_reset_l` rises at F+2+1024.
- **Short image (8000 bytes):** `load_err`=1, `load_ok`=0, `core_reset_l` stays 0 indefinitely.
- **Oversize image (8200 bytes):** writes at 8192..8199 produce no strobe; result is `ERROR`.
- **`user_rst` in `RUN`:** 5-cycle pulse; `core_reset_l`=0 from the next cycle until 1024 cycles after `user_rst` falls.
- **Coincident events:** a write on the cycle `ioctl_download` falls is counted. A new download starting during `HOLD` clears `load_ok` and keeps `core_reset_l`=0.
- **Reset mid-load:** `RESET_L` low after 3000 bytes gives `EMPTY`, all outputs 0 asynchronously. A following full load then succeeds.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// asteroids_pkg
//   Shared definitions for the Asteroids ROM download path.
//   - ROM_PROG_BYTES / ROM_VROM_BYTES : region sizes of the download image
//   - ROM_HOLD_CYCLES                 : default reset-settle interval
//   - rld_state_t                     : rom_load_ctrl sequencer states
//   - sat_inc16                       : saturating 16-bit increment
// ---------------------------------------------------------------------------
package asteroids_pkg;

   localparam int unsigned ROM_PROG_BYTES  = 6144;
   localparam int unsigned ROM_VROM_BYTES  = 2048;
   localparam int unsigned ROM_HOLD_CYCLES = 1024;

   // Fixed encodings keep state values stable for anything decoding them
   // from a probe or debug bus.
   typedef enum logic [2:0] {
      RLD_EMPTY = 3'd0,
      RLD_LOAD  = 3'd1,
      RLD_CHECK = 3'd2,
      RLD_HOLD  = 3'd3,
      RLD_RUN   = 3'd4,
      RLD_ERROR = 3'd5
   } rld_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/rom_load_ctrl_if.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl_if
//   Download bus between hps_io (ioctl side) and the ROM write side of the
//   core (dn side).
//   ioctl_download : download active          (master -> slave)
//   ioctl_wr       : byte write strobe        (master -> slave)
//   ioctl_addr     : byte address, 25 bits    (master -> slave)
//   ioctl_dout     : byte data                (master -> slave)
//   dn_addr        : region-relative address  (slave -> master)
//   dn_data        : byte data                (slave -> master)
//   dn_wr_prog     : program ROM write strobe (slave -> master)
//   dn_wr_vrom     : vector ROM write strobe  (slave -> master)
// ---------------------------------------------------------------------------
interface rom_load_ctrl_if;

   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr_prog;
   logic        dn_wr_vrom;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      input  dn_addr, dn_data, dn_wr_prog, dn_wr_vrom
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
      output dn_addr, dn_data, dn_wr_prog, dn_wr_vrom
   );

endinterface

// File: rtl/rom_load_ctrl_region_decode.sv
// ---------------------------------------------------------------------------
// rld_region_decode
//   Combinational split of a linear download address into ROM regions.
//   addr     in  25 : byte address within the download
//   prog_hit out  1 : addr falls in program ROM
//   vrom_hit out  1 : addr falls in vector ROM
//   over     out  1 : addr beyond the end of the image
//   rel_addr out 16 : address relative to the hit region (0 on overflow)
// ---------------------------------------------------------------------------
module rld_region_decode
   import asteroids_pkg::*;
#(
   parameter int unsigned PROG_SIZE = ROM_PROG_BYTES,
   parameter int unsigned VROM_SIZE = ROM_VROM_BYTES
) (
   input  logic [24:0] addr,
   output logic        prog_hit,
   output logic        vrom_hit,
   output logic        over,
   output logic [15:0] rel_addr
);

   localparam logic [24:0] PROG_END = 25'(PROG_SIZE);
   localparam logic [24:0] IMG_END  = 25'(PROG_SIZE + VROM_SIZE);

   always_comb begin
      prog_hit = 1'b0;
      vrom_hit = 1'b0;
      over     = 1'b0;
      rel_addr = '0;
      if (addr < PROG_END) begin
         prog_hit = 1'b1;
         rel_addr = addr[15:0];
      end else if (addr < IMG_END) begin
         vrom_hit = 1'b1;
         rel_addr = 16'(addr - PROG_END);
      end else begin
         over = 1'b1;
      end
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// ---------------------------------------------------------------------------
// rom_load_ctrl
//   Sequences the HPS ROM download into the Asteroids core and owns the
//   core reset. Splits the download stream into program / vector ROM write
//   strobes, validates the byte total and holds the core in reset until a
//   valid image is resident plus a settle interval. user_rst re-applies a
//   stretched reset once running.
//   clk_25       in   : system clock
//   RESET_L      in   : asynchronous active-low reset
//   bus          slave: ioctl download in, dn ROM write strobes out
//   user_rst     in   : level reset request (OSD / button)
//   core_reset_l out  : active-low reset to the core
//   load_ok      out  : a valid image is resident
//   load_err     out  : the last download was malformed
// ---------------------------------------------------------------------------
module rom_load_ctrl
   import asteroids_pkg::*;
#(
   parameter int unsigned PROG_SIZE   = ROM_PROG_BYTES,
   parameter int unsigned VROM_SIZE   = ROM_VROM_BYTES,
   parameter int unsigned HOLD_CYCLES = ROM_HOLD_CYCLES
) (
   input  logic              clk_25,
   input  logic              RESET_L,
   rom_load_ctrl_if.slave    bus,
   input  logic              user_rst,
   output logic              core_reset_l,
   output logic              load_ok,
   output logic              load_err
);

   localparam int unsigned          IMG_BYTES = PROG_SIZE + VROM_SIZE;
   localparam int unsigned          HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
   localparam logic [HOLD_W-1:0]    HOLD_ONE  = HOLD_W'(1);

   rld_state_t        state_q, state_d;
   logic [15:0]       byte_cnt_q, byte_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              over_q, over_d;
   logic              core_reset_l_q, core_reset_l_d;
   logic              load_ok_q, load_ok_d;
   logic              load_err_q, load_err_d;
   logic [15:0]       dn_addr_q, dn_addr_d;
   logic [7:0]        dn_data_q, dn_data_d;
   logic              wr_prog_q, wr_prog_d;
   logic              wr_vrom_q, wr_vrom_d;

   logic              dec_prog;
   logic              dec_vrom;
   logic              dec_over;
   logic [15:0]       dec_rel;
   logic              wr_accept;
   logic              dl_start;

   rld_region_decode #(
      .PROG_SIZE (PROG_SIZE),
      .VROM_SIZE (VROM_SIZE)
   ) u_decode (
      .addr     (bus.ioctl_addr),
      .prog_hit (dec_prog),
      .vrom_hit (dec_vrom),
      .over     (dec_over),
      .rel_addr (dec_rel)
   );

   // In LOAD a write is still taken on the cycle download drops, so the
   // final byte of a stream is never lost; elsewhere download must be high.
   assign wr_accept = bus.ioctl_wr && (bus.ioctl_download || (state_q == RLD_LOAD));

   assign dl_start  = bus.ioctl_download &&
                      (state_q inside {RLD_EMPTY, RLD_HOLD, RLD_RUN, RLD_ERROR});

   always_comb begin
      state_d        = state_q;
      byte_cnt_d     = byte_cnt_q;
      hold_cnt_d     = hold_cnt_q;
      over_d         = over_q;
      core_reset_l_d = core_reset_l_q;
      load_ok_d      = load_ok_q;
      load_err_d     = load_err_q;
      dn_addr_d      = dn_addr_q;
      dn_data_d      = dn_data_q;
      wr_prog_d      = 1'b0;
      wr_vrom_d      = 1'b0;

      // Write path: address/data only move on a region hit, so they hold
      // between strobes and through overflow bytes.
      if (wr_accept && (dec_prog || dec_vrom)) begin
         dn_addr_d = dec_rel;
         dn_data_d = bus.ioctl_dout;
         wr_prog_d = dec_prog;
         wr_vrom_d = dec_vrom;
      end

      case (state_q)
         RLD_LOAD: begin
            if (wr_accept) begin
               byte_cnt_d = sat_inc16(byte_cnt_q);
               over_d     = over_q | dec_over;
            end
            if (!bus.ioctl_download) begin
               state_d = RLD_CHECK;
            end
         end

         RLD_CHECK: begin
            if ((32'(byte_cnt_q) == IMG_BYTES) && !over_q) begin
               state_d    = RLD_HOLD;
               load_ok_d  = 1'b1;
               hold_cnt_d = HOLD_LOAD;
            end else begin
               state_d    = RLD_ERROR;
               load_err_d = 1'b1;
            end
         end

         RLD_HOLD: begin
            // Expiry fires on the decrement that reaches zero so reset
            // lasts exactly HOLD_CYCLES cycles after the reload.
            if (user_rst) begin
               hold_cnt_d = HOLD_LOAD;
            end else if (hold_cnt_q <= HOLD_ONE) begin
               hold_cnt_d     = '0;
               state_d        = RLD_RUN;
               core_reset_l_d = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q - HOLD_ONE;
            end
         end

         RLD_RUN: begin
            if (user_rst) begin
               state_d        = RLD_HOLD;
               hold_cnt_d     = HOLD_LOAD;
               core_reset_l_d = 1'b0;
            end
         end

         default: begin
         end
      endcase

      // A new download outranks every other event in the resting states.
      if (dl_start) begin
         state_d        = RLD_LOAD;
         byte_cnt_d     = wr_accept ? 16'd1 : 16'd0;
         over_d         = wr_accept && dec_over;
         hold_cnt_d     = '0;
         load_ok_d      = 1'b0;
         load_err_d     = 1'b0;
         core_reset_l_d = 1'b0;
      end
   end

   always_ff @(posedge clk_25 or negedge RESET_L) begin
      if (!RESET_L) begin
         state_q        <= RLD_EMPTY;
         byte_cnt_q     <= '0;
         hold_cnt_q     <= '0;
         over_q         <= 1'b0;
         core_reset_l_q <= 1'b0;
         load_ok_q      <= 1'b0;
         load_err_q     <= 1'b0;
         dn_addr_q      <= '0;
         dn_data_q      <= '0;
         wr_prog_q      <= 1'b0;
         wr_vrom_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         hold_cnt_q     <= hold_cnt_d;
         over_q         <= over_d;
         core_reset_l_q <= core_reset_l_d;
         load_ok_q      <= load_ok_d;
         load_err_q     <= load_err_d;
         dn_addr_q      <= dn_addr_d;
         dn_data_q      <= dn_data_d;
         wr_prog_q      <= wr_prog_d;
         wr_vrom_q      <= wr_vrom_d;
      end
   end

   assign bus.dn_addr    = dn_addr_q;
   assign bus.dn_data    = dn_data_q;
   assign bus.dn_wr_prog = wr_prog_q;
   assign bus.dn_wr_vrom = wr_vrom_q;
   assign core_reset_l   = core_reset_l_q;
   assign load_ok        = load_ok_q;
   assign load_err       = load_err_q;

endmodule
